// File: rtl/divider_16_bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Operands and results each move on a valid/ready handshake.
module divider_16_bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_low_borrow;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == '0);

  // Trial subtraction of D from the shifted partial remainder. The shifted
  // value is WIDTH+1 bits; a set top bit means it is certainly >= D.
  assign w_rem_shift                = {r_rem, r_quo[WIDTH-1]};
  assign {w_low_borrow, w_diff}     = {1'b0, w_rem_shift[WIDTH-1:0]} - {1'b0, r_div};
  assign w_borrow                   = ~w_rem_shift[WIDTH] & w_low_borrow;
  assign w_rem_next                 = w_borrow ? w_rem_shift[WIDTH-1:0] : w_diff;
  assign w_quo_next                 = {r_quo[WIDTH-2:0], ~w_borrow};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = (divisor != '0) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: this design holds only flops, so all of them are reset; a RAM-style
  // array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (divisor != '0) begin
              r_rem <= '0;
              r_quo <= dividend;
              r_div <= divisor;
              r_cnt <= CW'(WIDTH - 1);
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_16_bit_seq.sv
// Self-checking bench for divider_16_bit_seq: directed vectors, handshake
// corner sequences, and random operands against an arithmetic reference.
module tb_divider_16_bit_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  divider_16_bit_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [15:0] n, input logic [15:0] d,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z);
    if (d == 16'd0) begin
      q = 16'hFFFF;
      r = n;
      z = 1'b1;
    end else begin
      q = n / d;
      r = n % d;
      z = 1'b0;
    end
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // Starts at a negedge in IDLE; returns the result and the number of rising
  // edges after the accept edge before out_valid was seen.
  task automatic do_op(input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic z, output int lat);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        vecs[$];
  logic [15:0] q, r, eq, er;
  logic        z, ez;
  int          lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    vecs.push_back('{16'd1000,  16'd7,      16'd142,   16'd6,      1'b0, 16});
    vecs.push_back('{16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000,   1'b0, 16});
    vecs.push_back('{16'hFFFF,  16'hFFFF,   16'h0001,  16'h0000,   1'b0, 16});
    vecs.push_back('{16'd3,     16'd10,     16'd0,     16'd3,      1'b0, 16});
    vecs.push_back('{16'd5,     16'd0,      16'hFFFF,  16'd5,      1'b1, 0});
    vecs.push_back('{16'd6,     16'd3,      16'd2,     16'd0,      1'b0, 16});
    vecs.push_back('{16'd0,     16'd5,      16'd0,     16'd0,      1'b0, 16});
    vecs.push_back('{16'd0,     16'd0,      16'hFFFF,  16'd0,      1'b1, 0});
    vecs.push_back('{16'd40000, 16'd123,    16'd325,   16'd25,     1'b0, 16});
    vecs.push_back('{16'h8000,  16'h0002,   16'h4000,  16'h0000,   1'b0, 16});
    vecs.push_back('{16'hFFFF,  16'h8000,   16'h0001,  16'h7FFF,   1'b0, 16});
    vecs.push_back('{16'd1234,  16'd1234,   16'd1,     16'd0,      1'b0, 16});

    foreach (vecs[i]) begin
      do_op(vecs[i].n, vecs[i].d, q, r, z, lat);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].dbz));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held while out_ready stays low and inputs churn.
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd16);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q", 32'(quotient), 32'd142);
      check("bp_r", 32'(remainder), 32'd6);
      check("bp_dbz", 32'(div_by_zero), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_q_held", 32'(quotient), 32'd142);
    check("bp_release_r_held", 32'(remainder), 32'd6);

    // Reset during CALC iteration 8 of 40000/123 discards the operation.
    in_valid = 1'b1;
    dividend = 16'd40000;
    divisor  = 16'd123;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("calc_in_ready", 32'(in_ready), 32'd0);
    check("calc_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 32'(out_valid), 32'd0);
    do_op(16'd40000, 16'd123, q, r, z, lat);
    check("after_rst_q", 32'(q), 32'd325);
    check("after_rst_r", 32'(r), 32'd25);
    check("after_rst_dbz", 32'(z), 32'd0);

    for (int k = 0; k < 2500; k++) begin
      logic [15:0] n, d;
      n = pick();
      d = pick();
      ref_div(n, d, eq, er, ez);
      do_op(n, d, q, r, z, lat);
      check($sformatf("rnd_q %0h/%0h", n, d), 32'(q), 32'(eq));
      check($sformatf("rnd_r %0h/%0h", n, d), 32'(r), 32'(er));
      check($sformatf("rnd_dbz %0h/%0h", n, d), 32'(z), 32'(ez));
      check($sformatf("rnd_lat %0h/%0h", n, d), 32'(lat), (d == 16'd0) ? 32'd0 : 32'd16);
      if (d != 16'd0) begin
        check($sformatf("rnd_identity %0h/%0h", n, d), 32'(q) * 32'(d) + 32'(r), 32'(n));
        check($sformatf("rnd_r_lt_d %0h/%0h", n, d), 32'(r < d), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
